// File: rtl/memoria_dados_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores with a fixed wait-state
// count, stalling the pipeline until the access completes.
module memoria_dados_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  tamanho,
    input  logic        sem_sinal,
    input  logic [31:0] endereco,
    input  logic [31:0] dado_escrita,
    output logic [31:0] read_data,
    output logic        pronto,
    output logic        stall,
    output logic        erro_alinhamento
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {OCIOSO, ESPERA, CONCLUI} estado_t;

    estado_t     estado_q, estado_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] end_q, end_d;
    logic [1:0]  tam_q, tam_d;
    logic        sem_q, sem_d;
    logic [31:0] dado_q, dado_d;
    logic        escrita_q, escrita_d;
    logic [31:0] read_data_q, read_data_d;
    logic        pronto_q, pronto_d;
    logic        erro_q, erro_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]      acc_end, acc_dado, palavra, desl_b, desl_h, valor_load, mascara, dado_rep, palavra_nova;
    logic [1:0]       acc_tam;
    logic             acc_sem, acc_escrita, desalinhado, entra_conclui, grava;
    logic [IDX_W-1:0] acc_idx;
    logic             unused_end_alto;

    assign unused_end_alto = ^endereco[31:IDX_W+2];

    // The W=0 path enters CONCLUI straight from OCIOSO, so the access must be
    // evaluated from the live inputs there and from the captured copy elsewhere.
    always_comb begin
        acc_end     = (estado_q == OCIOSO) ? endereco     : end_q;
        acc_tam     = (estado_q == OCIOSO) ? tamanho      : tam_q;
        acc_sem     = (estado_q == OCIOSO) ? sem_sinal    : sem_q;
        acc_dado    = (estado_q == OCIOSO) ? dado_escrita : dado_q;
        acc_escrita = (estado_q == OCIOSO) ? mem_write    : escrita_q;
        acc_idx     = acc_end[IDX_W+1:2];
        palavra     = mem_q[acc_idx];
        desalinhado = ((acc_tam == 2'b01) && acc_end[0]) ||
                      (acc_tam[1] && (acc_end[1:0] != 2'b00));

        desl_b = palavra >> {acc_end[1:0], 3'b000};
        desl_h = palavra >> {acc_end[1], 4'b0000};
        case (acc_tam)
            2'b00:   valor_load = acc_sem ? {24'h0, desl_b[7:0]}  : {{24{desl_b[7]}}, desl_b[7:0]};
            2'b01:   valor_load = acc_sem ? {16'h0, desl_h[15:0]} : {{16{desl_h[15]}}, desl_h[15:0]};
            default: valor_load = palavra;
        endcase

        case (acc_tam)
            2'b00: begin
                mascara  = 32'h0000_00FF << {acc_end[1:0], 3'b000};
                dado_rep = {4{acc_dado[7:0]}};
            end
            2'b01: begin
                mascara  = 32'h0000_FFFF << {acc_end[1], 4'b0000};
                dado_rep = {2{acc_dado[15:0]}};
            end
            default: begin
                mascara  = '1;
                dado_rep = acc_dado;
            end
        endcase
        palavra_nova = (palavra & ~mascara) | (dado_rep & mascara);
        grava        = (estado_q == CONCLUI) && escrita_q && !desalinhado;
    end

    always_comb begin
        estado_d      = estado_q;
        cnt_d         = cnt_q;
        end_d         = end_q;
        tam_d         = tam_q;
        sem_d         = sem_q;
        dado_d        = dado_q;
        escrita_d     = escrita_q;
        read_data_d   = read_data_q;
        pronto_d      = 1'b0;
        erro_d        = 1'b0;
        stall         = 1'b0;
        entra_conclui = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (mem_read || mem_write) begin
                    stall     = 1'b1;
                    end_d     = endereco;
                    tam_d     = tamanho;
                    sem_d     = sem_sinal;
                    dado_d    = dado_escrita;
                    escrita_d = mem_write;
                    if (WAIT_CYCLES == 0) begin
                        estado_d      = CONCLUI;
                        entra_conclui = 1'b1;
                    end else begin
                        estado_d = ESPERA;
                        cnt_d    = CNT_INIT;
                    end
                end
            end
            ESPERA: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    estado_d      = CONCLUI;
                    entra_conclui = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CONCLUI: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
        if (entra_conclui) begin
            pronto_d = 1'b1;
            erro_d   = desalinhado;
            if (!acc_escrita && !desalinhado) read_data_d = valor_load;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            cnt_q       <= '0;
            end_q       <= '0;
            tam_q       <= '0;
            sem_q       <= 1'b0;
            dado_q      <= '0;
            escrita_q   <= 1'b0;
            read_data_q <= '0;
            pronto_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            end_q       <= end_d;
            tam_q       <= tam_d;
            sem_q       <= sem_d;
            dado_q      <= dado_d;
            escrita_q   <= escrita_d;
            read_data_q <= read_data_d;
            pronto_q    <= pronto_d;
            erro_q      <= erro_d;
        end
    end

    // Stores commit on the CONCLUI exit edge so a reset during CONCLUI drops them.
    always_ff @(posedge clock) begin
        if (grava) mem_q[acc_idx] <= palavra_nova;
    end

    assign read_data        = read_data_q;
    assign pronto           = pronto_q;
    assign erro_alinhamento = erro_q;
endmodule

// File: tb/tb_memoria_dados_ctrl.sv
// Bench for memoria_dados_ctrl: two instances (2 and 0 wait states) checked
// every cycle against a word-array reference model.
module tb_memoria_dados_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read [2];
    logic        mem_write [2];
    logic [1:0]  tamanho [2];
    logic        sem_sinal [2];
    logic [31:0] endereco [2];
    logic [31:0] dado_escrita [2];
    logic [31:0] read_data [2];
    logic        pronto [2];
    logic        stall [2];
    logic        erro [2];

    logic [31:0] mm [2][256];
    logic        exp_stall [2];
    logic        exp_pronto [2];
    logic        exp_erro [2];
    logic [31:0] exp_rd [2];
    logic        lit_on [2];
    logic [31:0] lit_val [2];
    logic        chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    memoria_dados_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_w2 (
        .clock(clock), .reset(reset), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .tamanho(tamanho[0]), .sem_sinal(sem_sinal[0]), .endereco(endereco[0]),
        .dado_escrita(dado_escrita[0]), .read_data(read_data[0]), .pronto(pronto[0]),
        .stall(stall[0]), .erro_alinhamento(erro[0]));

    memoria_dados_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .reset(reset), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .tamanho(tamanho[1]), .sem_sinal(sem_sinal[1]), .endereco(endereco[1]),
        .dado_escrita(dado_escrita[1]), .read_data(read_data[1]), .pronto(pronto[1]),
        .stall(stall[1]), .erro_alinhamento(erro[1]));

    always #5 clock = ~clock;

    function automatic int waits(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, i, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("stall", i, {31'b0, stall[i]}, {31'b0, exp_stall[i]});
                chk("pronto", i, {31'b0, pronto[i]}, {31'b0, exp_pronto[i]});
                chk("erro", i, {31'b0, erro[i]}, {31'b0, exp_erro[i]});
                chk("read_data", i, read_data[i], exp_rd[i]);
                if (lit_on[i]) chk("literal", i, read_data[i], lit_val[i]);
            end
        end
    end

    task automatic idle(input int i);
        mem_read[i]     = 1'b0;
        mem_write[i]    = 1'b0;
        tamanho[i]      = 2'b00;
        sem_sinal[i]    = 1'b0;
        endereco[i]     = '0;
        dado_escrita[i] = '0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 2; i++) begin
            exp_stall[i]  = 1'b0;
            exp_pronto[i] = 1'b0;
            exp_erro[i]   = 1'b0;
            exp_rd[i]     = '0;
            lit_on[i]     = 1'b0;
            lit_val[i]    = '0;
        end
    endtask

    // Called one step after a rising edge with instance i idle.
    task automatic access(input int i, input bit wr, input bit rd, input logic [1:0] sz,
                          input bit zx, input logic [31:0] a, input logic [31:0] d,
                          input bit use_lit, input logic [31:0] lit);
        int unsigned idx, lane;
        logic [31:0] w, v, mask, nw;
        bit mis;
        idx  = (a >> 2) % 256;
        lane = a % 4;
        w    = mm[i][idx];
        mis  = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && lane != 0);
        if (sz == 2'd0) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (!zx && v[7]) v = v | 32'hFFFF_FF00;
            mask = 32'hFF << (8 * lane);
        end else if (sz == 2'd1) begin
            v = (w >> (8 * lane)) & 32'hFFFF;
            if (!zx && v[15]) v = v | 32'hFFFF_0000;
            mask = 32'hFFFF << (8 * lane);
        end else begin
            v = w;
            mask = 32'hFFFF_FFFF;
        end
        nw = (w & ~mask) | ((d << (8 * lane)) & mask);

        mem_read[i] = rd; mem_write[i] = wr; tamanho[i] = sz; sem_sinal[i] = zx;
        endereco[i] = a;  dado_escrita[i] = d;
        exp_stall[i] = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < waits(i); k++) begin
            mem_read[i] = 1'b1; mem_write[i] = 1'($urandom);
            tamanho[i] = 2'($urandom); sem_sinal[i] = 1'($urandom);
            endereco[i] = $urandom; dado_escrita[i] = $urandom;
            exp_stall[i] = 1'b1;
            @(posedge clock); #1;
        end
        idle(i);
        exp_stall[i]  = 1'b0;
        exp_pronto[i] = 1'b1;
        exp_erro[i]   = mis;
        if (!mis) begin
            if (wr) mm[i][idx] = nw;
            else    exp_rd[i] = v;
        end
        lit_on[i]  = use_lit;
        lit_val[i] = lit;
        @(posedge clock); #1;
        exp_pronto[i] = 1'b0;
        exp_erro[i]   = 1'b0;
        lit_on[i]     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle(0); idle(1);
        clear_exp();
        chk_en = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        // 2 wait states: word store/load
        access(0, 1, 0, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0, '0);
        access(0, 0, 1, 2'd2, 0, 32'h10, '0, 1, 32'hDEAD_BEEF);
        // byte and half lanes
        access(0, 1, 0, 2'd2, 0, 32'h20, 32'h8081_7F02, 0, '0);
        access(0, 0, 1, 2'd0, 0, 32'h23, '0, 1, 32'hFFFF_FF80);
        access(0, 0, 1, 2'd0, 1, 32'h23, '0, 1, 32'h0000_0080);
        access(0, 0, 1, 2'd0, 0, 32'h21, '0, 1, 32'h0000_007F);
        access(0, 0, 1, 2'd1, 0, 32'h22, '0, 1, 32'hFFFF_8081);
        access(0, 0, 1, 2'd1, 1, 32'h20, '0, 1, 32'h0000_7F02);
        // partial stores
        access(0, 1, 0, 2'd2, 0, 32'h20, 32'h1122_3344, 0, '0);
        access(0, 1, 0, 2'd0, 0, 32'h21, 32'h1234_56AA, 0, '0);
        access(0, 0, 1, 2'd2, 0, 32'h20, '0, 1, 32'h1122_AA44);
        access(0, 1, 0, 2'd1, 0, 32'h22, 32'hFFFF_BEEF, 0, '0);
        access(0, 0, 1, 2'd2, 0, 32'h20, '0, 1, 32'hBEEF_AA44);
        // misaligned
        access(0, 0, 1, 2'd2, 0, 32'h22, '0, 1, 32'hBEEF_AA44);
        access(0, 1, 0, 2'd2, 0, 32'h30, 32'h0BAD_F00D, 0, '0);
        access(0, 1, 0, 2'd1, 0, 32'h31, 32'h0000_9999, 0, '0);
        access(0, 0, 1, 2'd2, 0, 32'h30, '0, 1, 32'h0BAD_F00D);
        access(0, 0, 1, 2'd1, 1, 32'h33, '0, 1, 32'h0BAD_F00D);
        // both requests high is a store; size 11 is a word
        access(0, 1, 1, 2'd2, 0, 32'h50, 32'h0000_0077, 0, '0);
        access(0, 0, 1, 2'd3, 0, 32'h50, '0, 1, 32'h0000_0077);

        // reset in the middle of a store
        access(0, 1, 0, 2'd2, 0, 32'h40, 32'hCAFE_F00D, 0, '0);
        mem_write[0] = 1'b1; tamanho[0] = 2'd2; endereco[0] = 32'h40;
        dado_escrita[0] = 32'h1234_5678;
        exp_stall[0] = 1'b1;
        @(posedge clock); #1;
        idle(0);
        reset = 1'b1;
        clear_exp();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        access(0, 0, 1, 2'd2, 0, 32'h40, '0, 1, 32'hCAFE_F00D);

        // zero wait states and address wrap
        access(1, 1, 0, 2'd2, 0, 32'h400, 32'h0000_0055, 0, '0);
        access(1, 0, 1, 2'd2, 0, 32'h0, '0, 1, 32'h0000_0055);
        access(1, 0, 1, 2'd2, 0, 32'h3, '0, 1, 32'h0000_0055);
        access(1, 0, 1, 2'd0, 0, 32'h400, '0, 1, 32'h0000_0055);

        repeat (2) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memoria_dados_ctrl.md
# memoria_dados_ctrl

Multi-cycle data-memory access unit for the MIPS processor. It sits in the MEM stage and is the producer of `read_data` for the write-back mem-to-reg mux. The ALU result is the address. The unit performs byte, halfword and word loads/stores against an internal word array with a configurable wait-state count, and stalls the pipeline until the access completes.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words in the array (power of two).
- `WAIT_CYCLES`, 2: wait states per access (0..15).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mem_read`  in  1  load request (level).
- `mem_write`  in  1  store request (level); wins over `mem_read` if both are high.
- `tamanho`  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `sem_sinal`  in  1  1 = zero-extend loads (lbu/lhu); 0 = sign-extend.
- `endereco`  in  32  byte address (ALUResult).
- `dado_escrita`  in  32  store data; low byte/half is used for sb/sh.
- `read_data`  out  32  load result, held until the next completed load.
- `pronto`  out  1  one-cycle pulse: access finished.
- `stall`  out  1  freeze the pipeline while the access is pending.
- `erro_alinhamento`  out  1  one-cycle pulse alongside `pronto` for a misaligned access.

## Operation
- FSM states: OCIOSO, ESPERA, CONCLUI.
- **OCIOSO:**
  - On `mem_read|mem_write`, capture address, size, sign mode, data and operation.
  - Go to ESPERA with counter = `WAIT_CYCLES`-1. If `WAIT_CYCLES`=0, go directly to CONCLUI.
- **ESPERA:** decrement the counter; at 0 go to CONCLUI. Request inputs are ignored; captured values are used.
- **CONCLUI:**
  - Perform the access and pulse `pronto`, then return to OCIOSO.
  - If a request is still high in the following OCIOSO cycle, it starts a new access. The pipeline must drop or change the request after `pronto`.
- Word index = `endereco[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap.
- Little-endian lanes: byte lane = `endereco[1:0]`; halfword lane = `endereco[1]`.
- **Stores:** only the addressed byte or half is modified; other bytes of the word are preserved.
- **Loads:** the selected lane is right-justified, then sign- or zero-extended per `sem_sinal`. Word loads ignore `sem_sinal`.
- **Misalignment:** halfword with `endereco[0]`=1, or word with `endereco[1:0]`≠0.
  - No array write; `read_data` unchanged.
  - `erro_alinhamento`=1 together with `pronto`.
  - Full wait latency still applies.
- Both requests high: treated as a store; `read_data` unchanged.
- Array contents are not cleared by reset.

## Timing
- `stall` = (OCIOSO & (`mem_read`|`mem_write`)) | ESPERA. It is combinational in OCIOSO so the request cycle is already stalled. `stall`=0 in CONCLUI.
- Request first seen high at edge T: `pronto` is high in cycle T+`WAIT_CYCLES`+1. For a load, `read_data` is valid from that same cycle (registered at the CONCLUI entry edge) and holds afterward.
- `stall` is high for exactly `WAIT_CYCLES`+1 cycles per access.
- Back-to-back throughput: one access per `WAIT_CYCLES`+2 cycles.
- Reset values: state OCIOSO, `read_data`=0, `pronto`=0, `erro_alinhamento`=0, counter 0. `stall` follows its equation (0 while the request inputs are low).
- Reset mid-access (in ESPERA or CONCLUI): abort immediately; no array write; no `pronto`.
- Request inputs changing during ESPERA have no effect on the access in flight.

## Test plan
- **Word store then load** (`WAIT_CYCLES`=2):
  - sw 0xDEADBEEF @0x10 → `stall` high 3 cycles; `pronto` at T+3.
  - lw @0x10 → `read_data`=0xDEADBEEF at its `pronto`.
- **Byte and half lanes:** after word 0x8081_7F02 @0x20:
  - lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080; lb @0x21 → 0x0000007F.
  - lh @0x22 → 0xFFFF8081; lhu @0x20 → 0x00007F02.
- **Partial store:** sb 0xAA @0x21 over 0x11223344 → lw @0x20 = 0x1122AA44. sh 0xBEEF @0x22 → 0xBEEFAA44.
- **Misaligned access:** lw @0x22 → `erro_alinhamento`=1 with `pronto`, `read_data` keeps its prior value. sh @0x31 → word @0x30 unchanged.
- **Reset mid-access:** assert `reset` during ESPERA of sw 0x12345678 @0x40 → no `pronto`, word @0x40 unchanged, `read_data`=0, `stall`=0 with requests low.
- **`WAIT_CYCLES`=0 and wrap:**
  - `stall` 1 cycle; `pronto` at T+1.
  - `DEPTH_WORDS`=256: sw 0x55 @0x400 then lw @0x0 → 0x00000055.
